// File: rtl/led_uart_reporter.sv
// Reports every change of the LED byte over UART as two uppercase hex chars plus CR.
// Optional even parity bit per character when LED_UART_PARITY_EN is defined.
module led_uart_reporter #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [7:0] iLed,
   output logic       oTx,
   output logic       oBusy
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef LED_UART_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2:0]       bit_idx, bit_n;
   logic [1:0]       char_idx, char_n;
   logic [7:0]       snap, snap_n;
   logic [7:0]       pend, pend_n;
   logic             pend_vld, pend_vld_n;
   logic [7:0]       led_prev;
   logic             tx, tx_n;
   logic             busy, busy_n;

   logic             change;
   logic [7:0]       cur_char;
   logic [2:0]       next_bit;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   assign change   = (iLed != led_prev);
   assign next_bit = bit_idx + 3'd1;

   always_comb begin
      case (char_idx)
         2'd0:    cur_char = hex_char(snap[7:4]);
         2'd1:    cur_char = hex_char(snap[3:0]);
         default: cur_char = 8'h0D;
      endcase
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      bit_n      = bit_idx;
      char_n     = char_idx;
      snap_n     = snap;
      pend_n     = pend;
      pend_vld_n = pend_vld;
      tx_n       = tx;
      busy_n     = busy;

      if (state == IDLE) begin
         tx_n   = 1'b1;
         busy_n = 1'b0;
         if (change) begin
            snap_n  = iLed;
            state_n = START;
            cnt_n   = '0;
            char_n  = '0;
            tx_n    = 1'b0;
            busy_n  = 1'b1;
         end
      end else begin
         if (change) begin
            pend_n     = iLed;
            pend_vld_n = 1'b1;
         end
         if (cnt != CNT_LAST) begin
            cnt_n = cnt + 1'b1;
         end else begin
            cnt_n = '0;
            case (state)
               START: begin
                  state_n = DATA;
                  bit_n   = '0;
                  tx_n    = cur_char[0];
               end
               DATA: begin
                  if (bit_idx == 3'd7) begin
`ifdef LED_UART_PARITY_EN
                     state_n = PARITY;
                     tx_n    = ^cur_char;
`else
                     state_n = STOP;
                     tx_n    = 1'b1;
`endif
                  end else begin
                     bit_n = next_bit;
                     tx_n  = cur_char[next_bit];
                  end
               end
`ifdef LED_UART_PARITY_EN
               PARITY: begin
                  state_n = STOP;
                  tx_n    = 1'b1;
               end
`endif
               STOP: begin
                  if (char_idx != 2'd2) begin
                     char_n  = char_idx + 2'd1;
                     state_n = START;
                     tx_n    = 1'b0;
                  end else if (change || pend_vld) begin
                     // a change on the final edge is newer than anything pending
                     snap_n     = change ? iLed : pend;
                     pend_vld_n = 1'b0;
                     char_n     = '0;
                     state_n    = START;
                     tx_n       = 1'b0;
                  end else begin
                     state_n = IDLE;
                     tx_n    = 1'b1;
                     busy_n  = 1'b0;
                  end
               end
               default: begin
                  state_n = IDLE;
                  tx_n    = 1'b1;
                  busy_n  = 1'b0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         char_idx <= '0;
         snap     <= '0;
         pend     <= '0;
         pend_vld <= 1'b0;
         led_prev <= '0;
         tx       <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         bit_idx  <= bit_n;
         char_idx <= char_n;
         snap     <= snap_n;
         pend     <= pend_n;
         pend_vld <= pend_vld_n;
         led_prev <= iLed;
         tx       <= tx_n;
         busy     <= busy_n;
      end
   end

   assign oTx   = tx;
   assign oBusy = busy;

endmodule
